// File: rtl/regfile_hilo_pkg.sv
// Shared constants for the write-back to register-file bus.
// Holds the bus width and the bit position of every field in the packed bus.
package regfile_hilo_pkg;

  // Total width of the packed write-back bus
  localparam int WB_TO_RF_WD = 104;

  // HI write enable and data field
  localparam int WB_HI_WE        = 103;
  localparam int WB_HI_WDATA_MSB = 102;
  localparam int WB_HI_WDATA_LSB = 71;

  // LO write enable and data field
  localparam int WB_LO_WE        = 70;
  localparam int WB_LO_WDATA_MSB = 69;
  localparam int WB_LO_WDATA_LSB = 38;

  // GPR write enable, address and data fields
  localparam int WB_RF_WE        = 37;
  localparam int WB_RF_WADDR_MSB = 36;
  localparam int WB_RF_WADDR_LSB = 32;
  localparam int WB_RF_WDATA_MSB = 31;
  localparam int WB_RF_WDATA_LSB = 0;

endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// HI/LO special registers used by multiply/divide results.
// Optional feature macro: WB_BYPASS_EN forwards write data to the read outputs
// during the write cycle; otherwise writes become visible one cycle later.
module hilo_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          hi_we,
  input  logic [DW-1:0] hi_wdata,
  input  logic          lo_we,
  input  logic [DW-1:0] lo_wdata,
  output logic [DW-1:0] hi_rdata,
  output logic [DW-1:0] lo_rdata
);

  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;

  // Commit HI and LO independently; reset wins over any pending write
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

  // Present stored values, optionally overridden by this cycle's write data
  always_comb begin
    hi_rdata = hi_q;
    lo_rdata = lo_q;
`ifdef WB_BYPASS_EN
    if (resetn && hi_we) hi_rdata = hi_wdata;
    if (resetn && lo_we) lo_rdata = lo_wdata;
`endif
  end

endmodule

// File: rtl/regfile_hilo.sv
// MIPS architectural state: 32x32 GPR file plus HI/LO, fed by the write-back bus.
// Two combinational GPR read ports and HI/LO reads for the decode stage.
// Optional feature macro: WB_BYPASS_EN forwards the in-flight write to the
// read outputs in the same cycle (never for r0, never while in reset).
module regfile_hilo
  import regfile_hilo_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
  input  logic [4:0]             raddr1,
  output logic [DW-1:0]          rdata1,
  input  logic [4:0]             raddr2,
  output logic [DW-1:0]          rdata2,
  output logic [DW-1:0]          hi_rdata,
  output logic [DW-1:0]          lo_rdata
);

  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          hi_we;
  logic [DW-1:0] hi_wdata;
  logic          lo_we;
  logic [DW-1:0] lo_wdata;

  logic [DW-1:0] regs [NREG];

  assign hi_we    = wb_to_rf_bus[WB_HI_WE];
  assign hi_wdata = wb_to_rf_bus[WB_HI_WDATA_MSB:WB_HI_WDATA_LSB];
  assign lo_we    = wb_to_rf_bus[WB_LO_WE];
  assign lo_wdata = wb_to_rf_bus[WB_LO_WDATA_MSB:WB_LO_WDATA_LSB];
  assign rf_we    = wb_to_rf_bus[WB_RF_WE];
  assign rf_waddr = wb_to_rf_bus[WB_RF_WADDR_MSB:WB_RF_WADDR_LSB];
  assign rf_wdata = wb_to_rf_bus[WB_RF_WDATA_MSB:WB_RF_WDATA_LSB];

  // Clear every GPR on reset, otherwise commit a write to any register except r0
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Read ports: r0 is hardwired to zero, optional forwarding of the in-flight write
  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
`ifdef WB_BYPASS_EN
    if (resetn && rf_we && rf_waddr != 5'd0 && raddr1 == rf_waddr) rdata1 = rf_wdata;
    if (resetn && rf_we && rf_waddr != 5'd0 && raddr2 == rf_waddr) rdata2 = rf_wdata;
`endif
  end

  hilo_reg #(
    .DW(DW)
  ) u_hilo (
    .clk      (clk),
    .resetn   (resetn),
    .hi_we    (hi_we),
    .hi_wdata (hi_wdata),
    .lo_we    (lo_we),
    .lo_wdata (lo_wdata),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata)
  );

endmodule

// File: tb/tb_regfile_hilo.sv
// Self-checking bench for regfile_hilo: directed vector table, hand-written
// reset/bubble sequences and randomized traffic against an array-based model.
// Expectations follow WB_BYPASS_EN when the macro is defined for the build.
module tb_regfile_hilo;

  logic         clk = 1'b0;
  logic         resetn;
  logic [103:0] wb_to_rf_bus;
  logic [4:0]   raddr1;
  logic [4:0]   raddr2;
  logic [31:0]  rdata1;
  logic [31:0]  rdata2;
  logic [31:0]  hi_rdata;
  logic [31:0]  lo_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst_n;
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        lo_we;
    logic [31:0] lo_wdata;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs [9];
  vec_t cur;

  logic [31:0] gpr_m [32];
  logic [31:0] hi_m;
  logic [31:0] lo_m;
  logic [31:0] snap_gpr [32];
  logic [31:0] snap_hi;
  logic [31:0] snap_lo;

  regfile_hilo dut (
    .clk          (clk),
    .resetn       (resetn),
    .wb_to_rf_bus (wb_to_rf_bus),
    .raddr1       (raddr1),
    .rdata1       (rdata1),
    .raddr2       (raddr2),
    .rdata2       (rdata2),
    .hi_rdata     (hi_rdata),
    .lo_rdata     (lo_rdata)
  );

  // Free-running core clock
  always #5 clk = ~clk;

  function automatic logic bypass_on();
`ifdef WB_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected GPR read given the stored value and this cycle's bus
  function automatic logic [31:0] exp_gpr(vec_t v, logic [4:0] a, logic [31:0] stored);
    if (a == 5'd0) return 32'd0;
    if (bypass_on() && v.rst_n && v.rf_we && v.waddr != 5'd0 && v.waddr == a) return v.wdata;
    return stored;
  endfunction

  function automatic logic [31:0] exp_hl(logic rst_n, logic we, logic [31:0] wd, logic [31:0] stored);
    if (bypass_on() && rst_n && we) return wd;
    return stored;
  endfunction

  // Drive one cycle's inputs just after the falling edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    resetn       = v.rst_n;
    wb_to_rf_bus = {v.hi_we, v.hi_wdata, v.lo_we, v.lo_wdata, v.rf_we, v.waddr, v.wdata};
    raddr1       = v.ra1;
    raddr2       = v.ra2;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all four outputs against the model's view of the current cycle
  task automatic checkModel(input string tag, input vec_t v);
    checkOutput({tag, " rdata1"}, rdata1, exp_gpr(v, v.ra1, gpr_m[v.ra1]));
    checkOutput({tag, " rdata2"}, rdata2, exp_gpr(v, v.ra2, gpr_m[v.ra2]));
    checkOutput({tag, " hi"}, hi_rdata, exp_hl(v.rst_n, v.hi_we, v.hi_wdata, hi_m));
    checkOutput({tag, " lo"}, lo_rdata, exp_hl(v.rst_n, v.lo_we, v.lo_wdata, lo_m));
  endtask

  // Pass the rising edge and apply the architectural effect of the bus to the model
  task automatic commitEdge(input vec_t v);
    @(posedge clk);
    if (!v.rst_n) begin
      for (int i = 0; i < 32; i++) gpr_m[i] = 32'd0;
      hi_m = 32'd0;
      lo_m = 32'd0;
    end else begin
      if (v.rf_we && v.waddr != 5'd0) gpr_m[v.waddr] = v.wdata;
      if (v.hi_we) hi_m = v.hi_wdata;
      if (v.lo_we) lo_m = v.lo_wdata;
    end
  endtask

  function automatic vec_t rand_vec(int rst_pct);
    vec_t v;
    v.rst_n    = ($urandom_range(99) >= rst_pct);
    v.hi_we    = ($urandom_range(99) < 30);
    v.hi_wdata = $urandom;
    v.lo_we    = ($urandom_range(99) < 30);
    v.lo_wdata = $urandom;
    v.rf_we    = ($urandom_range(99) < 60);
    v.waddr    = 5'($urandom_range(31));
    v.wdata    = $urandom;
    v.ra1      = ($urandom_range(3) == 0) ? v.waddr : 5'($urandom_range(31));
    v.ra2      = 5'($urandom_range(31));
    v.e1 = 0; v.e2 = 0; v.ehi = 0; v.elo = 0;
    return v;
  endfunction

  function automatic vec_t idle_vec(logic [4:0] a1, logic [4:0] a2);
    vec_t v;
    v = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, a1, a2, 32'd0, 32'd0, 32'd0, 32'd0};
    return v;
  endfunction

  initial begin
    // Directed table: expected values are the stored state seen before the edge
    vecs[0] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h00000012, 1'b1, 32'h34567890, 1'b1, 5'd8, 32'h00000001, 5'd0, 5'd6, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'hAAAA0000, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd8, 5'd5, 32'h1,        32'hDEADBEEF, 32'h12,       32'h34567890};
    vecs[4] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 5'd3, 32'h00000055, 5'd3, 5'd3, 32'h0,        32'h0,        32'hAAAA0000, 32'h34567890};
    vecs[5] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd3, 5'd8, 32'h55,       32'h1,        32'hAAAA0000, 32'h34567890};
    vecs[6] = '{1'b0, 1'b1, 32'h00000099, 1'b0, 32'h0,        1'b1, 5'd9, 32'h00000077, 5'd9, 5'd3, 32'h0,        32'h55,       32'hAAAA0000, 32'h34567890};
    vecs[7] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd9, 5'd3, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd8, 32'h0,        32'h0,        32'h0,        32'h0};

    // Bring-up reset; outputs are undefined before it so nothing is checked
    cur = idle_vec(5'd0, 5'd0);
    cur.rst_n = 1'b0;
    applyStimulus(cur);
    commitEdge(cur);

    // Random writes, then a one-cycle reset carrying a random write that must be dropped
    for (int i = 0; i < 12; i++) begin
      cur = rand_vec(0);
      applyStimulus(cur);
      checkModel("prefill", cur);
      commitEdge(cur);
    end
    cur = rand_vec(0);
    cur.rst_n = 1'b0;
    cur.rf_we = 1'b1;
    cur.hi_we = 1'b1;
    cur.lo_we = 1'b1;
    applyStimulus(cur);
    commitEdge(cur);
    for (int i = 0; i < 16; i++) begin
      cur = idle_vec(5'(i), 5'(i + 16));
      applyStimulus(cur);
      checkOutput("post-reset rdata1", rdata1, 32'd0);
      checkOutput("post-reset rdata2", rdata2, 32'd0);
      checkOutput("post-reset hi", hi_rdata, 32'd0);
      checkOutput("post-reset lo", lo_rdata, 32'd0);
      commitEdge(cur);
    end

    // Directed vectors, with in-cycle forwarding folded in when the build enables it
    for (int i = 0; i < 9; i++) begin
      cur = vecs[i];
      applyStimulus(cur);
      checkOutput($sformatf("vec%0d rdata1", i), rdata1, exp_gpr(cur, cur.ra1, cur.e1));
      checkOutput($sformatf("vec%0d rdata2", i), rdata2, exp_gpr(cur, cur.ra2, cur.e2));
      checkOutput($sformatf("vec%0d hi", i), hi_rdata, exp_hl(cur.rst_n, cur.hi_we, cur.hi_wdata, cur.ehi));
      checkOutput($sformatf("vec%0d lo", i), lo_rdata, exp_hl(cur.rst_n, cur.lo_we, cur.lo_wdata, cur.elo));
      commitEdge(cur);
    end

    // Randomized traffic with occasional mid-stream resets
    for (int i = 0; i < 400; i++) begin
      cur = rand_vec(3);
      applyStimulus(cur);
      checkModel("random", cur);
      commitEdge(cur);
    end

    // Ten bubbles must leave every register, HI and LO untouched
    for (int i = 0; i < 32; i++) snap_gpr[i] = gpr_m[i];
    snap_hi = hi_m;
    snap_lo = lo_m;
    for (int i = 0; i < 10; i++) begin
      cur = idle_vec(5'(i), 5'(31 - i));
      cur.ra1 = 5'(i + 1);
      applyStimulus(cur);
      commitEdge(cur);
    end
    for (int i = 0; i < 32; i++) begin
      cur = idle_vec(5'(i), 5'(31 - i));
      applyStimulus(cur);
      checkOutput("bubble rdata1", rdata1, (i == 0) ? 32'd0 : snap_gpr[i]);
      checkOutput("bubble rdata2", rdata2, (i == 31) ? 32'd0 : snap_gpr[31 - i]);
      checkOutput("bubble hi", hi_rdata, snap_hi);
      checkOutput("bubble lo", lo_rdata, snap_lo);
      commitEdge(cur);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
